// File: rtl/ppu_palette_pkg.sv
// Shared types, field layout and power-on colour table for the PPU palette store.
package ppu_palette_pkg;

    localparam int COLOR_W    = 6;
    localparam int ENTRIES    = 32;
    localparam int ADDR_W     = 5;
    localparam int SPRITE_BIT = 4;

    localparam logic [ADDR_W-1:0] LAST_ENTRY = ADDR_W'(ENTRIES - 1);

    typedef enum logic {
        INIT,
        RUN
    } ctrl_state_t;

    // One queued CPU write: target entry and colour.
    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [COLOR_W-1:0] data;
    } wr_req_t;

    // Colour 0 of every palette, BG or sprite, resolves to the shared backdrop entry.
    function automatic logic [ADDR_W-1:0] lookup_addr(input logic       sprite,
                                                      input logic [1:0] palette,
                                                      input logic [1:0] color);
        return (color == 2'd0) ? '0 : {sprite, palette, color};
    endfunction

    // Sprite colour-0 slots alias onto the matching BG colour-0 slots.
    function automatic logic [ADDR_W-1:0] mirror_addr(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] mapped;
        mapped = addr;
        if (addr[1:0] == 2'b00)
            mapped[SPRITE_BIT] = 1'b0;
        return mapped;
    endfunction

    // Power-on colours, indexed by {palette, color}; the sprite set repeats the BG set.
    function automatic logic [COLOR_W-1:0] default_color(input logic [3:0] idx);
        logic [COLOR_W-1:0] c;
        case (idx)
            4'h1:                c = 6'h03;
            4'h2:                c = 6'h0C;
            4'h3:                c = 6'h30;
            4'h5:                c = 6'h3C;
            4'h6:                c = 6'h33;
            4'h7:                c = 6'h0F;
            4'h9:                c = 6'h30;
            4'hA:                c = 6'h03;
            4'hB:                c = 6'h0C;
            4'hD, 4'hE, 4'hF:    c = 6'h30;
            default:             c = 6'h00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/palette_wr_fifo.sv
// Small FIFO holding CPU palette writes until a render-free cycle drains them.
// The caller guarantees push only when not full and pop only when not empty.
module palette_wr_fifo
    import ppu_palette_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  wr_req_t                    push_req,
    input  logic                       pop,
    output wr_req_t                    head_req,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    wr_req_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointer and occupancy tracking; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Entry storage.
    // NOTE: storage is deliberately not reset; occupancy comes from the reset
    // pointers/count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_req;
    end

    assign head_req = mem[rd_ptr];

endmodule

// File: rtl/palette_ram_ctrl.sv
// Palette store for the PPU colour path: loads default colours after reset,
// serves one render lookup per cycle and drains queued CPU writes in cycles
// without a lookup.
module palette_ram_ctrl
    import ppu_palette_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_valid,
    input  logic               rd_sprite,
    input  logic [1:0]         rd_palette,
    input  logic [1:0]         rd_color,
    output logic [COLOR_W-1:0] system_color,
    output logic               color_valid,
    input  logic               cpu_wr_valid,
    input  logic [ADDR_W-1:0]  cpu_wr_addr,
    input  logic [COLOR_W-1:0] cpu_wr_data,
    output logic               cpu_wr_ready,
    output logic               wr_pending,
    output logic               init_done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

    ctrl_state_t        state;
    ctrl_state_t        next_state;
    logic [ADDR_W-1:0]  init_idx;

    logic [COLOR_W-1:0] store [ENTRIES];
    logic               st_we;
    logic [ADDR_W-1:0]  st_waddr;
    logic [COLOR_W-1:0] st_wdata;

    logic               fifo_push;
    logic               fifo_pop;
    wr_req_t            fifo_in;
    wr_req_t            fifo_head;
    logic [CNT_W-1:0]   fifo_count;

    logic               lookup_en;
    logic [ADDR_W-1:0]  rd_addr;

    assign init_done    = (state == RUN);
    assign cpu_wr_ready = (state == RUN) && (fifo_count < FULL_CNT);
    assign wr_pending   = (fifo_count != '0);
    assign fifo_push    = cpu_wr_valid && cpu_wr_ready;
    assign fifo_in      = '{addr: cpu_wr_addr, data: cpu_wr_data};
    assign lookup_en    = rd_valid && (state == RUN);
    assign rd_addr      = lookup_addr(rd_sprite, rd_palette, rd_color);

    palette_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_req (fifo_in),
        .pop      (fifo_pop),
        .head_req (fifo_head),
        .count    (fifo_count)
    );

    // State register and init index sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            init_idx <= '0;
        end else begin
            state <= next_state;
            if (state == INIT)
                init_idx <= init_idx + IDX_ONE;
        end
    end

    // Next state and store write port: default load during INIT, queue drain in RUN.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and no latch is inferred.
        next_state = state;
        st_we      = 1'b0;
        st_waddr   = '0;
        st_wdata   = '0;
        fifo_pop   = 1'b0;
        case (state)
            INIT: begin
                st_we    = 1'b1;
                st_waddr = init_idx;
                st_wdata = default_color(init_idx[3:0]);
                if (init_idx == LAST_ENTRY)
                    next_state = RUN;
            end
            RUN: begin
                if (wr_pending && !rd_valid) begin
                    fifo_pop = 1'b1;
                    st_we    = 1'b1;
                    st_waddr = mirror_addr(fifo_head.addr);
                    st_wdata = fifo_head.data;
                end
            end
            default: next_state = INIT;
        endcase
    end

    // Palette store; contents are rebuilt by INIT after every reset.
    always_ff @(posedge clk) begin
        if (st_we) store[st_waddr] <= st_wdata;
    end

    // Registered render lookup; system_color holds its last value when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            system_color <= '0;
            color_valid  <= 1'b0;
        end else begin
            color_valid <= lookup_en;
            if (lookup_en)
                system_color <= store[rd_addr];
        end
    end

endmodule

// File: tb/tb_palette_ram_ctrl.sv
// Self-checking bench for palette_ram_ctrl: a behavioural model of the store
// and write queue feeds an expected-colour scoreboard.
module tb_palette_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rd_valid;
    logic       rd_sprite;
    logic [1:0] rd_palette;
    logic [1:0] rd_color;
    logic [5:0] system_color;
    logic       color_valid;
    logic       cpu_wr_valid;
    logic [4:0] cpu_wr_addr;
    logic [5:0] cpu_wr_data;
    logic       cpu_wr_ready;
    logic       wr_pending;
    logic       init_done;

    always #5 clk = ~clk;

    palette_ram_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .rd_valid     (rd_valid),
        .rd_sprite    (rd_sprite),
        .rd_palette   (rd_palette),
        .rd_color     (rd_color),
        .system_color (system_color),
        .color_valid  (color_valid),
        .cpu_wr_valid (cpu_wr_valid),
        .cpu_wr_addr  (cpu_wr_addr),
        .cpu_wr_data  (cpu_wr_data),
        .cpu_wr_ready (cpu_wr_ready),
        .wr_pending   (wr_pending),
        .init_done    (init_done)
    );

    typedef struct packed {
        logic [4:0] addr;
        logic [5:0] data;
    } mw_t;

    logic [5:0] dflt [16] = '{6'h00, 6'h03, 6'h0C, 6'h30,
                              6'h00, 6'h3C, 6'h33, 6'h0F,
                              6'h00, 6'h30, 6'h03, 6'h0C,
                              6'h00, 6'h30, 6'h30, 6'h30};

    logic [5:0] m_mem [32];
    mw_t        m_q [$];
    logic [5:0] exp_q [$];
    int         m_init;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] m_store_addr(input logic [4:0] a);
        case (a)
            5'h10:   return 5'h00;
            5'h14:   return 5'h04;
            5'h18:   return 5'h08;
            5'h1C:   return 5'h0C;
            default: return a;
        endcase
    endfunction

    function automatic logic [5:0] m_look(input logic s, input logic [1:0] p, input logic [1:0] c);
        if (c == 2'd0) return m_mem[0];
        return m_mem[{s, p, c}];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = dflt[i % 16];
        m_q.delete();
        exp_q.delete();
        m_init = 0;
    endtask

    task automatic set_rd(input logic v, input logic s, input logic [1:0] p, input logic [1:0] c);
        rd_valid   = v;
        rd_sprite  = s;
        rd_palette = p;
        rd_color   = c;
    endtask

    task automatic set_wr(input logic v, input logic [4:0] a, input logic [5:0] d);
        cpu_wr_valid = v;
        cpu_wr_addr  = a;
        cpu_wr_data  = d;
    endtask

    // One clock: predict the edge from the model, advance, then compare.
    task automatic step();
        bit         run;
        bit         acc;
        bit         drn;
        bit         exp_v;
        logic [5:0] exp_c;
        mw_t        w;
        run = (m_init == 32);
        check("wr_ready", cpu_wr_ready, run && (m_q.size() < 4));
        acc   = run && cpu_wr_valid && (m_q.size() < 4);
        drn   = run && (m_q.size() != 0) && !rd_valid;
        exp_v = run && rd_valid;
        if (exp_v) exp_q.push_back(m_look(rd_sprite, rd_palette, rd_color));
        @(posedge clk);
        if (drn) begin
            w = m_q.pop_front();
            m_mem[m_store_addr(w.addr)] = w.data;
        end
        if (acc) begin
            w.addr = cpu_wr_addr;
            w.data = cpu_wr_data;
            m_q.push_back(w);
        end
        if (!run) m_init++;
        #1;
        check("color_valid", color_valid, exp_v);
        if (exp_v) begin
            exp_c = exp_q.pop_front();
            check("color", system_color, exp_c);
        end
        check("wr_pending", wr_pending, m_q.size() != 0);
        check("init_done", init_done, m_init == 32);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic cpu_write(input logic [4:0] a, input logic [5:0] d);
        bit took;
        took = 1'b0;
        set_wr(1'b1, a, d);
        for (int i = 0; i < 20 && !took; i++) begin
            took = cpu_wr_ready;
            step();
        end
        check("wr_accept_timeout", took, 1'b1);
        set_wr(1'b0, 5'h00, 6'h00);
    endtask

    task automatic lookup(input string tag, input logic s, input logic [1:0] p,
                          input logic [1:0] c, input logic [5:0] exp);
        set_rd(1'b1, s, p, c);
        step();
        check(tag, system_color, exp);
        set_rd(1'b0, 1'b0, 2'd0, 2'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] w_a [5];
        logic [5:0] w_d [5];
        w_a = '{5'h05, 5'h06, 5'h05, 5'h0B, 5'h1E};
        w_d = '{6'h11, 6'h22, 6'h33, 6'h2C, 6'h15};

        rst = 1'b1;
        set_rd(1'b0, 1'b0, 2'd0, 2'd0);
        set_wr(1'b0, 5'h00, 6'h00);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_color", system_color, 6'h00);
        check("rst_valid", color_valid, 1'b0);
        check("rst_ready", cpu_wr_ready, 1'b0);
        check("rst_pending", wr_pending, 1'b0);
        check("rst_init_done", init_done, 1'b0);
        rst = 1'b0;

        // INIT: lookups and CPU writes are ignored for 32 cycles.
        set_rd(1'b1, 1'b0, 2'd1, 2'd2);
        set_wr(1'b1, 5'h03, 6'h3F);
        idle(32);
        check("init_done_c33", init_done, 1'b1);
        set_wr(1'b0, 5'h00, 6'h00);
        step();
        check("bg1_c2", system_color, 6'h33);

        // Render lookups keep a queued write pending until a gap appears.
        set_rd(1'b1, 1'b1, 2'd1, 2'd1);
        cpu_write(5'h15, 6'h2A);
        idle(3);
        check("starved_pending", wr_pending, 1'b1);
        check("starved_old", system_color, 6'h3C);
        set_rd(1'b0, 1'b0, 2'd0, 2'd0);
        step();
        lookup("spr1_c1_new", 1'b1, 2'd1, 2'd1, 6'h2A);

        // Fill the queue under continuous lookups; fifth write waits for a drain.
        set_rd(1'b1, 1'b0, 2'd1, 2'd1);
        for (int i = 0; i < 4; i++) begin
            set_wr(1'b1, w_a[i], w_d[i]);
            step();
        end
        set_wr(1'b1, w_a[4], w_d[4]);
        idle(2);
        check("full_ready", cpu_wr_ready, 1'b0);
        set_rd(1'b0, 1'b0, 2'd0, 2'd0);
        step();
        check("ready_after_drain", cpu_wr_ready, 1'b1);
        set_rd(1'b1, 1'b0, 2'd1, 2'd1);
        step();
        set_wr(1'b0, 5'h00, 6'h00);
        set_rd(1'b0, 1'b0, 2'd0, 2'd0);
        idle(6);
        check("drained", wr_pending, 1'b0);
        lookup("same_addr_last_wins", 1'b0, 2'd1, 2'd1, 6'h33);
        lookup("order_06", 1'b0, 2'd1, 2'd2, 6'h22);
        lookup("order_0b", 1'b0, 2'd2, 2'd3, 6'h2C);
        lookup("order_1e", 1'b1, 2'd3, 2'd2, 6'h15);

        // Backdrop sharing and mirroring of sprite colour-0 slots.
        cpu_write(5'h18, 6'h11);
        idle(2);
        lookup("spr2_c0_backdrop", 1'b1, 2'd2, 2'd0, 6'h00);
        lookup("bg3_c0_backdrop", 1'b0, 2'd3, 2'd0, 6'h00);
        cpu_write(5'h00, 6'h07);
        idle(2);
        lookup("bg2_c0_after_wr", 1'b0, 2'd2, 2'd0, 6'h07);
        cpu_write(5'h10, 6'h09);
        idle(2);
        lookup("mirror_10_spr0", 1'b1, 2'd0, 2'd0, 6'h09);
        lookup("mirror_10_bg1", 1'b0, 2'd1, 2'd0, 6'h09);

        // Reset in the middle of draining a queue.
        lookup("pre_rst_color", 1'b0, 2'd1, 2'd2, 6'h22);
        set_rd(1'b1, 1'b0, 2'd1, 2'd3);
        cpu_write(5'h01, 6'h3F);
        cpu_write(5'h02, 6'h3E);
        cpu_write(5'h03, 6'h3D);
        set_rd(1'b0, 1'b0, 2'd0, 2'd0);
        step();
        rst = 1'b1;
        #1;
        check("mid_rst_color", system_color, 6'h00);
        check("mid_rst_valid", color_valid, 1'b0);
        check("mid_rst_pending", wr_pending, 1'b0);
        check("mid_rst_ready", cpu_wr_ready, 1'b0);
        check("mid_rst_init_done", init_done, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        idle(32);
        check("reinit_done", init_done, 1'b1);
        for (int e = 0; e < 32; e++) begin
            logic [4:0] ea;
            logic [5:0] ev;
            ea = 5'(e);
            ev = (ea[1:0] == 2'd0) ? 6'h00 : dflt[ea[3:0]];
            lookup("reinit_default", ea[4], ea[3:2], ea[1:0], ev);
        end

        // Lookup issued with the write reads the old value; after the drain, the new one.
        set_rd(1'b1, 1'b0, 2'd1, 2'd2);
        set_wr(1'b1, 5'h06, 6'h21);
        step();
        check("wr_same_edge_old", system_color, 6'h33);
        set_wr(1'b0, 5'h00, 6'h00);
        set_rd(1'b0, 1'b0, 2'd0, 2'd0);
        step();
        lookup("wr_next_cycle_new", 1'b0, 2'd1, 2'd2, 6'h21);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
